lsb_pq: RTL

- Parametrised successor of the in-order load-store buffer; sits between decoder/ROB and the memory controller.
- Circular queue of DEPTH entries, issued in order, one memory request outstanding at a time.
- Operand wake-up from N_CDB generic broadcast channels plus its own result.
- Speculative loads: normal-region loads issue without waiting for the ROB head; stores and IO-region loads issue only at ROB head.

---
 rtl/lsb_pq.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsb_pq.sv
// lsb_pq: in-order load/store queue between the decoder/ROB and the memory
// controller.
//
// A circular buffer of DEPTH = 2**DEPTH_BITS entries. Entries issue strictly
// from the head, with one memory request outstanding at a time.
//
// Operands wake up from N_CDB broadcast channels and from this block's own
// result. Loads below IO_BASE issue speculatively. Stores and IO-region loads
// wait until their ROB id is at the ROB head.
//
// Ports
//   clk_in, rst_in, rdy_in   clock, async active-high reset, global enable
//   rob_*                    flush, ROB empty flag and ROB head id
//   is_dc, dc_*              decoder insert strobe and entry fields
//   lsb_full                 asserted when count >= DEPTH-1
//   cdb_*                    packed broadcast channels (valid/tag/value)
//   mem_res_avail, mem_res   memory completion pulse and load data
//   mem_stuck                memory cannot accept a request this cycle
//   is_io..io_op             registered one-cycle memory request
//   lsb_has_output..         registered one-cycle result broadcast
module lsb_pq #(
  parameter int          DEPTH_BITS = 3,
  parameter int          ROB_BITS   = 3,
  parameter int          N_CDB      = 1,
  parameter logic [31:0] IO_BASE    = 32'h00030000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_clear,
  input  logic                      rob_empty,
  input  logic [ROB_BITS-1:0]       rob_head_id,
  input  logic                      is_dc,
  input  logic [10:0]               dc_op,
  input  logic [31:0]               dc_imm,
  input  logic                      dc_iQi,
  input  logic [ROB_BITS-1:0]       dc_Qi,
  input  logic                      dc_iQj,
  input  logic [ROB_BITS-1:0]       dc_Qj,
  input  logic [ROB_BITS-1:0]       dc_Qdest,
  input  logic [31:0]               dc_Vi,
  input  logic [31:0]               dc_Vj,
  output logic                      lsb_full,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*ROB_BITS-1:0] cdb_rob_id,
  input  logic [N_CDB*32-1:0]       cdb_data,
  input  logic                      mem_res_avail,
  input  logic [31:0]               mem_res,
  input  logic                      mem_stuck,
  output logic                      is_io,
  output logic                      is_store,
  output logic [31:0]               io_addr,
  output logic [31:0]               io_data,
  output logic [2:0]                io_op,
  output logic                      lsb_has_output,
  output logic [ROB_BITS-1:0]       lsb_rob_id,
  output logic [31:0]               lsb_output
);

  localparam int         DEPTH     = 1 << DEPTH_BITS;
  localparam int         CNT_W     = DEPTH_BITS + 1;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef logic [ROB_BITS-1:0] tag_t;
  typedef struct packed {
    logic        hit;
    logic [31:0] val;
  } snoop_t;

  // ins[30] carries no meaning for loads and stores.
  logic unused_op_bit;
  assign unused_op_bit = dc_op[10];

  // Entry storage. Each slot is rewritten on insert, so it needs no reset.
  logic [9:0]  op_q    [DEPTH];
  logic [31:0] imm_q   [DEPTH];
  logic [31:0] vi_q    [DEPTH];
  logic [31:0] vj_q    [DEPTH];
  logic        iqi_q   [DEPTH];
  logic        iqj_q   [DEPTH];
  tag_t        qi_q    [DEPTH];
  tag_t        qj_q    [DEPTH];
  tag_t        qdest_q [DEPTH];

  // Control state and registered outputs.
  logic [DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q, busy_d, drop_q, drop_d;
  logic                  is_io_q, is_io_d, is_store_q, is_store_d;
  logic [31:0]           io_addr_q, io_addr_d, io_data_q, io_data_d;
  logic [2:0]            io_op_q, io_op_d;
  logic                  has_out_q, has_out_d;
  tag_t                  rob_id_q, rob_id_d;
  logic [31:0]           out_q, out_d;

  // Search order: own result first, then the lowest-index channel.
  // The loop runs from the highest index down, so later matches win.
  function automatic snoop_t snoop(input tag_t tag);
    snoop_t s;
    s = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && cdb_rob_id[k*ROB_BITS +: ROB_BITS] == tag)
        s = '{hit: 1'b1, val: cdb_data[k*32 +: 32]};
    end
    if (has_out_q && rob_id_q == tag)
      s = '{hit: 1'b1, val: out_q};
    return s;
  endfunction

  snoop_t si [DEPTH];
  snoop_t sj [DEPTH];
  snoop_t dc_si, dc_sj;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      si[i] = snoop(qi_q[i]);
      sj[i] = snoop(qj_q[i]);
    end
    dc_si = snoop(dc_Qi);
    dc_sj = snoop(dc_Qj);
  end

  // Head-of-queue decode and the issue decision.
  logic [31:0] head_addr;
  logic        head_is_load, head_is_store, head_ready, at_rob_head;
  logic        issue_ok, complete;

  assign head_addr     = vi_q[head_q] + imm_q[head_q];
  assign head_is_load  = op_q[head_q][6:0] == OPC_LOAD;
  assign head_is_store = op_q[head_q][6:0] == OPC_STORE;
  assign head_ready    = iqi_q[head_q] && (!head_is_store || iqj_q[head_q]);
  assign at_rob_head   = !rob_empty && rob_head_id == qdest_q[head_q];
  assign issue_ok      = count_q != '0 && !busy_q && !drop_q && !mem_stuck &&
                         head_ready &&
                         ((head_is_load && head_addr < IO_BASE) || at_rob_head);
  assign complete      = mem_res_avail && busy_q && !drop_q;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    busy_d     = busy_q;
    drop_d     = drop_q;
    is_io_d    = 1'b0;
    is_store_d = is_store_q;
    io_addr_d  = io_addr_q;
    io_data_d  = io_data_q;
    io_op_d    = io_op_q;
    has_out_d  = 1'b0;
    rob_id_d   = rob_id_q;
    out_d      = out_q;
    if (rob_clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = 1'b0;
      // A request in flight must have its response swallowed. A response
      // arriving in this same cycle is simply discarded.
      drop_d  = (busy_q || drop_q) && !mem_res_avail;
    end else begin
      if (mem_res_avail && drop_q)
        drop_d = 1'b0;
      if (complete) begin
        has_out_d = 1'b1;
        rob_id_d  = qdest_q[head_q];
        out_d     = is_store_q ? 32'h0 : mem_res;
        head_d    = head_q + 1'b1;
        busy_d    = 1'b0;
      end
      // issue_ok requires busy=0, so it never overlaps a completion.
      if (issue_ok) begin
        is_io_d    = 1'b1;
        is_store_d = head_is_store;
        io_addr_d  = head_addr;
        io_data_d  = vj_q[head_q];
        io_op_d    = op_q[head_q][9:7];
        busy_d     = 1'b1;
      end
      if (is_dc)
        tail_d = tail_q + 1'b1;
      count_d = count_q + CNT_W'(is_dc) - CNT_W'(complete);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // sample pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      is_io_q    <= 1'b0;
      is_store_q <= 1'b0;
      io_addr_q  <= '0;
      io_data_q  <= '0;
      io_op_q    <= '0;
      has_out_q  <= 1'b0;
      rob_id_q   <= '0;
      out_q      <= '0;
    end else if (rdy_in) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      is_io_q    <= is_io_d;
      is_store_q <= is_store_d;
      io_addr_q  <= io_addr_d;
      io_data_q  <= io_data_d;
      io_op_q    <= io_op_d;
      has_out_q  <= has_out_d;
      rob_id_q   <= rob_id_d;
      out_q      <= out_d;
    end
  end

  // NOTE: the entry arrays are plain storage with no reset. Slots outside the
  // occupied window may wake up spuriously; this is harmless because insert
  // overwrites every field.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!iqi_q[i] && si[i].hit) begin
          iqi_q[i] <= 1'b1;
          vi_q[i]  <= si[i].val;
        end
        if (!iqj_q[i] && sj[i].hit) begin
          iqj_q[i] <= 1'b1;
          vj_q[i]  <= sj[i].val;
        end
      end
      // The tail slot is never occupied (lsb_full stops the decoder at
      // DEPTH-1), so this later write safely overrides any wake-up above.
      if (is_dc && !rob_clear) begin
        op_q[tail_q]    <= dc_op[9:0];
        imm_q[tail_q]   <= dc_imm;
        qi_q[tail_q]    <= dc_Qi;
        qj_q[tail_q]    <= dc_Qj;
        qdest_q[tail_q] <= dc_Qdest;
        iqi_q[tail_q]   <= dc_iQi || dc_si.hit;
        vi_q[tail_q]    <= dc_iQi ? dc_Vi : dc_si.val;
        iqj_q[tail_q]   <= dc_iQj || dc_sj.hit;
        vj_q[tail_q]    <= dc_iQj ? dc_Vj : dc_sj.val;
      end
    end
  end

  assign lsb_full       = count_q >= CNT_W'(DEPTH - 1);
  assign is_io          = is_io_q;
  assign is_store       = is_store_q;
  assign io_addr        = io_addr_q;
  assign io_data        = io_data_q;
  assign io_op          = io_op_q;
  assign lsb_has_output = has_out_q;
  assign lsb_rob_id     = rob_id_q;
  assign lsb_output     = out_q;

endmodule
